regfile_writeback: RTL and testbench

//  Writeback stage directly upstream of the register file; sole owner of its write port (A3/WE3/WD3).
//  - ALU results: written one cycle after acceptance.
//  - Loads: issues a word read to the SPI memory interface and waits for the ack.

---
 rtl/regfile_wb_pkg.sv | 25 ++
 rtl/regfile_writeback_load_extend.sv | 38 +++
 rtl/regfile_writeback.sv | 164 ++++++++++++++++
 tb/tb_regfile_writeback.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_pkg.sv
// Shared types and constants for the register-file writeback stage.
// Optional feature macro: WB_MISALIGN_CHECK_EN (see regfile_writeback.sv).
package regfile_wb_pkg;

    typedef enum logic {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } wb_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Byte loads never misalign; halfwords need an even address; everything else is a word.
    function automatic logic load_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_LB, F3_LBU: return 1'b0;
            F3_LH, F3_LHU: return off[0];
            default:       return (off != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/regfile_writeback_load_extend.sv
// Combinational lane select and sign/zero extension of a loaded word.
// Unlisted funct3 encodings fall through to a full-word load.
module load_extend
    import regfile_wb_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    function automatic logic [31:0] sext8(input logic signed [7:0] v);
        return {{24{v[7]}}, v};
    endfunction

    function automatic logic [31:0] sext16(input logic signed [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    assign byte_sel = rdata[{off, 3'b000} +: 8];
    assign half_sel = off[1] ? rdata[31:16] : rdata[15:0];

    // Pick the lane and extend it according to the load type.
    always_comb begin
        result = rdata;
        case (funct3)
            F3_LB:   result = sext8(byte_sel);
            F3_LBU:  result = {24'h0, byte_sel};
            F3_LH:   result = sext16(half_sel);
            F3_LHU:  result = {16'h0, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/regfile_writeback.sv
// Writeback stage: sole owner of the register-file write port (A3/WE3/WD3).
// ALU results are written one cycle after acceptance; loads fetch a word over
// the SPI memory interface, extend it and then write rd.
// Optional feature macro: WB_MISALIGN_CHECK_EN rejects misaligned LH/LHU/LW.
module regfile_writeback
    import regfile_wb_pkg::*;
#(
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic        wb_is_load,
    input  logic [4:0]  wb_rd,
    input  logic [2:0]  wb_funct3,
    input  logic [31:0] wb_data,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [4:0]  A3,
    output logic        WE3,
    output logic [31:0] WD3,
    output logic        load_busy,
    output logic [4:0]  load_rd,
    output logic        timeout_err,
    output logic        misalign_err
);

    localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    wb_state_t          state_q, state_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic               mem_req_q, mem_req_n;
    logic [31:0]        mem_addr_q, mem_addr_n;
    logic [4:0]         a3_q, a3_n;
    logic               we3_q, we3_n;
    logic [31:0]        wd3_q, wd3_n;
    logic               busy_q, busy_n;
    logic [4:0]         load_rd_q, load_rd_n;
    logic               timeout_q, timeout_n;
    logic               misalign_q, misalign_n;
    logic [1:0]         off_q, off_n;
    logic [2:0]         f3_q, f3_n;
    logic               accept;
    logic               misalign_hit;
    logic [31:0]        load_result;

`ifdef WB_MISALIGN_CHECK_EN
    assign misalign_hit = load_misaligned(wb_funct3, wb_data[1:0]);
`else
    assign misalign_hit = 1'b0;
`endif

    assign wb_ready = (state_q == IDLE);
    assign accept   = wb_valid & wb_ready;

    load_extend u_load_extend (
        .rdata  (mem_rdata),
        .off    (off_q),
        .funct3 (f3_q),
        .result (load_result)
    );

    // Next-state and next-output decode; write enable and error pulses default low.
    always_comb begin
        state_n    = state_q;
        cnt_n      = cnt_q;
        mem_req_n  = mem_req_q;
        mem_addr_n = mem_addr_q;
        a3_n       = a3_q;
        we3_n      = 1'b0;
        wd3_n      = wd3_q;
        busy_n     = busy_q;
        load_rd_n  = load_rd_q;
        timeout_n  = 1'b0;
        misalign_n = 1'b0;
        off_n      = off_q;
        f3_n       = f3_q;
        case (state_q)
            IDLE: begin
                if (accept && !wb_is_load) begin
                    we3_n = (wb_rd != 5'd0);
                    a3_n  = wb_rd;
                    wd3_n = wb_data;
                end else if (accept && misalign_hit) begin
                    misalign_n = 1'b1;
                end else if (accept) begin
                    state_n    = LOAD_WAIT;
                    cnt_n      = '0;
                    mem_req_n  = 1'b1;
                    mem_addr_n = {wb_data[31:2], 2'b00};
                    busy_n     = 1'b1;
                    load_rd_n  = wb_rd;
                    off_n      = wb_data[1:0];
                    f3_n       = wb_funct3;
                end
            end
            LOAD_WAIT: begin
                if (mem_ack) begin
                    state_n   = IDLE;
                    we3_n     = (load_rd_q != 5'd0);
                    a3_n      = load_rd_q;
                    wd3_n     = load_result;
                    mem_req_n = 1'b0;
                    busy_n    = 1'b0;
                end else if ((ACK_TIMEOUT != 0) && (cnt_q == CNT_W'(ACK_TIMEOUT - 1))) begin
                    state_n   = IDLE;
                    timeout_n = 1'b1;
                    mem_req_n = 1'b0;
                    busy_n    = 1'b0;
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers; reset aborts any load in flight.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            a3_q       <= '0;
            we3_q      <= 1'b0;
            wd3_q      <= '0;
            busy_q     <= 1'b0;
            load_rd_q  <= '0;
            timeout_q  <= 1'b0;
            misalign_q <= 1'b0;
            off_q      <= '0;
            f3_q       <= '0;
        end else begin
            state_q    <= state_n;
            cnt_q      <= cnt_n;
            mem_req_q  <= mem_req_n;
            mem_addr_q <= mem_addr_n;
            a3_q       <= a3_n;
            we3_q      <= we3_n;
            wd3_q      <= wd3_n;
            busy_q     <= busy_n;
            load_rd_q  <= load_rd_n;
            timeout_q  <= timeout_n;
            misalign_q <= misalign_n;
            off_q      <= off_n;
            f3_q       <= f3_n;
        end
    end

    assign mem_req      = mem_req_q;
    assign mem_addr     = mem_addr_q;
    assign A3           = a3_q;
    assign WE3          = we3_q;
    assign WD3          = wd3_q;
    assign load_busy    = busy_q;
    assign load_rd      = load_rd_q;
    assign timeout_err  = timeout_q;
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback with a write scoreboard.
// Honours WB_MISALIGN_CHECK_EN to select the expected misaligned-load outcome.
module tb_regfile_writeback;

    logic        CLK = 1'b0;
    logic        reset;
    logic        wb_valid;
    logic        wb_ready;
    logic        wb_is_load;
    logic [4:0]  wb_rd;
    logic [2:0]  wb_funct3;
    logic [31:0] wb_data;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [4:0]  A3;
    logic        WE3;
    logic [31:0] WD3;
    logic        load_busy;
    logic [4:0]  load_rd;
    logic        timeout_err;
    logic        misalign_err;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];

    regfile_writeback #(.ACK_TIMEOUT(8)) dut (
        .CLK          (CLK),
        .reset        (reset),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_is_load   (wb_is_load),
        .wb_rd        (wb_rd),
        .wb_funct3    (wb_funct3),
        .wb_data      (wb_data),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .A3           (A3),
        .WE3          (WE3),
        .WD3          (WD3),
        .load_busy    (load_busy),
        .load_rd      (load_rd),
        .timeout_err  (timeout_err),
        .misalign_err (misalign_err)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample #1 later; every write is matched against the scoreboard.
    task automatic cycle();
        wr_t e;
        @(posedge CLK);
        #1;
        if (WE3 === 1'b1) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_write: observed A3=%0d WD3=%h expected no write", A3, WD3);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_A3", 32'(A3), 32'(e.rd));
                chk("sb_WD3", WD3, e.data);
            end
        end
    endtask

    task automatic alu_req(input logic [4:0] rd, input logic [31:0] data);
        wb_valid   = 1'b1;
        wb_is_load = 1'b0;
        wb_rd      = rd;
        wb_data    = data;
        if (rd != 5'd0) exp_q.push_back('{rd: rd, data: data});
        cycle();
        wb_valid = 1'b0;
    endtask

    // Issue a load, ack it after ack_delay waiting cycles and expect exp_wd in rd.
    task automatic load_req(input string tag, input logic [2:0] f3, input logic [4:0] rd,
                            input logic [31:0] addr, input logic [31:0] rdata,
                            input int ack_delay, input logic [31:0] exp_wd);
        wb_valid   = 1'b1;
        wb_is_load = 1'b1;
        wb_rd      = rd;
        wb_funct3  = f3;
        wb_data    = addr;
        cycle();
        wb_valid = 1'b0;
        chk({tag, "_mem_req"}, 32'(mem_req), 32'd1);
        chk({tag, "_mem_addr"}, mem_addr, {addr[31:2], 2'b00});
        chk({tag, "_busy"}, 32'(load_busy), 32'd1);
        chk({tag, "_load_rd"}, 32'(load_rd), 32'(rd));
        chk({tag, "_ready_low"}, 32'(wb_ready), 32'd0);
        for (int i = 0; i < ack_delay; i++) cycle();
        chk({tag, "_busy_wait"}, 32'(load_busy), 32'd1);
        if (rd != 5'd0) exp_q.push_back('{rd: rd, data: exp_wd});
        mem_ack   = 1'b1;
        mem_rdata = rdata;
        cycle();
        mem_ack = 1'b0;
        chk({tag, "_we3"}, 32'(WE3), (rd != 5'd0) ? 32'd1 : 32'd0);
        chk({tag, "_mem_req_done"}, 32'(mem_req), 32'd0);
        chk({tag, "_busy_done"}, 32'(load_busy), 32'd0);
        chk({tag, "_ready_back"}, 32'(wb_ready), 32'd1);
    endtask

    initial begin
        int k;
        reset      = 1'b1;
        wb_valid   = 1'b0;
        wb_is_load = 1'b0;
        wb_rd      = '0;
        wb_funct3  = '0;
        wb_data    = '0;
        mem_ack    = 1'b0;
        mem_rdata  = '0;
        cycle();
        cycle();
        reset = 1'b0;

        // Reset state
        chk("rst_ready", 32'(wb_ready), 32'd1);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_we3", 32'(WE3), 32'd0);
        chk("rst_a3", 32'(A3), 32'd0);
        chk("rst_wd3", WD3, 32'h0);
        chk("rst_busy", 32'(load_busy), 32'd0);
        chk("rst_load_rd", 32'(load_rd), 32'd0);
        chk("rst_timeout", 32'(timeout_err), 32'd0);
        chk("rst_misalign", 32'(misalign_err), 32'd0);

        // Single ALU write
        alu_req(5'd5, 32'hDEADBEEF);
        chk("alu1_we3", 32'(WE3), 32'd1);
        cycle();
        chk("alu1_we3_drop", 32'(WE3), 32'd0);

        // Back-to-back ALU writes
        for (int i = 1; i <= 3; i++) begin
            wb_valid   = 1'b1;
            wb_is_load = 1'b0;
            wb_rd      = 5'(i);
            wb_data    = 32'h1000_0000 + 32'(i);
            exp_q.push_back('{rd: 5'(i), data: 32'h1000_0000 + 32'(i)});
            chk("b2b_ready", 32'(wb_ready), 32'd1);
            cycle();
            chk("b2b_we3", 32'(WE3), 32'd1);
        end
        wb_valid = 1'b0;
        cycle();
        chk("b2b_we3_drop", 32'(WE3), 32'd0);

        // ALU write to x0 is suppressed
        alu_req(5'd0, 32'h12345678);
        chk("alu_x0_we3", 32'(WE3), 32'd0);

        // Loads with extension
        load_req("lb",  3'b000, 5'd9,  32'h103, 32'h80FF_0000, 3, 32'hFFFFFF80);
        load_req("lbu", 3'b100, 5'd10, 32'h103, 32'h80FF_0000, 3, 32'h00000080);
        load_req("lb0", 3'b000, 5'd11, 32'h200, 32'h1234_567F, 0, 32'h0000007F);
        load_req("lh",  3'b001, 5'd12, 32'h102, 32'h8001_1234, 1, 32'hFFFF8001);
        load_req("lhu", 3'b101, 5'd13, 32'h102, 32'h8001_1234, 1, 32'h00008001);
        load_req("lh0", 3'b001, 5'd14, 32'h300, 32'h0000_F00F, 2, 32'hFFFFF00F);
        load_req("lw",  3'b010, 5'd15, 32'h400, 32'hA5A5_5A5A, 2, 32'hA5A5_5A5A);
        load_req("f3_7", 3'b111, 5'd16, 32'h404, 32'h0BAD_F00D, 1, 32'h0BAD_F00D);
        load_req("lw_x0", 3'b010, 5'd0, 32'h500, 32'hFFFF_FFFF, 2, 32'h0);

        // Timeout: no ack
        wb_valid   = 1'b1;
        wb_is_load = 1'b1;
        wb_rd      = 5'd20;
        wb_funct3  = 3'b010;
        wb_data    = 32'h600;
        cycle();
        wb_valid = 1'b0;
        chk("to_mem_req", 32'(mem_req), 32'd1);
        k = 0;
        while (timeout_err !== 1'b1 && k < 20) begin
            cycle();
            k++;
        end
        chk("to_latency", 32'(k), 32'd8);
        chk("to_we3", 32'(WE3), 32'd0);
        chk("to_ready", 32'(wb_ready), 32'd1);
        chk("to_mem_req_drop", 32'(mem_req), 32'd0);
        chk("to_busy_drop", 32'(load_busy), 32'd0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h7777_7777;
        cycle();
        mem_ack = 1'b0;
        chk("to_pulse_end", 32'(timeout_err), 32'd0);
        chk("late_ack_we3", 32'(WE3), 32'd0);
        chk("late_ack_ready", 32'(wb_ready), 32'd1);

        // Reset in the middle of a load
        wb_valid   = 1'b1;
        wb_is_load = 1'b1;
        wb_rd      = 5'd21;
        wb_funct3  = 3'b010;
        wb_data    = 32'h700;
        cycle();
        wb_valid = 1'b0;
        chk("rl_mem_req", 32'(mem_req), 32'd1);
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("rl_mem_req_drop", 32'(mem_req), 32'd0);
        chk("rl_busy_drop", 32'(load_busy), 32'd0);
        chk("rl_ready", 32'(wb_ready), 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h5555_AAAA;
        cycle();
        mem_ack = 1'b0;
        chk("rl_stale_ack_we3", 32'(WE3), 32'd0);
        chk("rl_stale_ack_mem_req", 32'(mem_req), 32'd0);

        // Misaligned word load
`ifdef WB_MISALIGN_CHECK_EN
        wb_valid   = 1'b1;
        wb_is_load = 1'b1;
        wb_rd      = 5'd7;
        wb_funct3  = 3'b010;
        wb_data    = 32'h101;
        cycle();
        wb_valid = 1'b0;
        chk("mis_err", 32'(misalign_err), 32'd1);
        chk("mis_mem_req", 32'(mem_req), 32'd0);
        chk("mis_we3", 32'(WE3), 32'd0);
        chk("mis_ready", 32'(wb_ready), 32'd1);
        cycle();
        chk("mis_err_pulse", 32'(misalign_err), 32'd0);
        chk("mis_mem_req_after", 32'(mem_req), 32'd0);
`else
        load_req("lw_mis", 3'b010, 5'd7, 32'h101, 32'hCAFE_F00D, 1, 32'hCAFE_F00D);
        chk("nomis_err", 32'(misalign_err), 32'd0);
`endif

        alu_req(5'd31, 32'h0F0F_0F0F);
        cycle();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
